sram_2p_be: RTL and testbench
=============================

SRAM_2P_BE -- requirements
Module: sram_2p_be

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDRWIDTH, default 4, address width; DEPTH = 2**ADDRWIDTH entries.
REQ-003 SHALL have parameter NBYTE, default WIDTH/8, number of byte lanes; derived, not overridden.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port w_en  input  1  write request.
REQ-007 SHALL have port waddr  input  ADDRWIDTH  write address.
REQ-008 SHALL have port wdata  input  WIDTH  write data.
REQ-009 SHALL have port wbe  input  NBYTE  byte write enables; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port r_en  input  1  read request.
REQ-011 SHALL have port raddr  input  ADDRWIDTH  read address.
REQ-012 SHALL have port rdata  output  WIDTH  registered read data.
REQ-013 SHALL have port rvalid  output  1  one-cycle pulse qualifying rdata.
REQ-014 SHALL have port init_busy  output  1  high while the memory clear sequence runs.

Function
REQ-015 SHALL contain an init FSM with states INIT and READY plus an ADDRWIDTH-bit clear counter.
REQ-016 In INIT, SHALL write all-zero to entry clr_cnt every cycle, incrementing clr_cnt; after entry DEPTH-1 is written, SHALL move to READY on the next edge (exactly DEPTH cycles in INIT).
REQ-017 init_busy SHALL be 1 exactly while state is INIT.
REQ-018 In INIT, SHALL ignore w_en and r_en; rvalid stays 0.
REQ-019 In READY, w_en=1 SHALL update only byte lanes of mem[waddr] with wbe bit set; w_en=1 with wbe=0 SHALL leave memory unchanged.
REQ-020 In READY, r_en=1 at edge N SHALL produce rdata=mem[raddr] and rvalid=1 after edge N+1 (latency 1); rvalid SHALL be 0 in cycles without a preceding accepted read.
REQ-021 rdata SHALL hold its last value when no read is accepted.
REQ-022 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-023 Simultaneous read and write to the same address SHALL follow the Configuration section.
REQ-024 Addresses SHALL wrap naturally within ADDRWIDTH bits; no out-of-range checking.

Reset
REQ-025 With rst_n=0 at a rising edge: state=INIT, clr_cnt=0, rdata=0, rvalid=0, init_busy=1.
REQ-026 Reset asserted mid-INIT or mid-read SHALL restart clearing from entry 0 and discard any pending read result.
REQ-027 Memory array contents SHALL NOT be reset directly; zeroing is done only by the INIT sequence.

Configuration
REQ-028 Macro SRAM_2P_BE_BYPASS_EN defined: same-address read and write in one cycle SHALL return write-first data, i.e. per lane wdata where wbe set, old mem content elsewhere.
REQ-029 Macro SRAM_2P_BE_BYPASS_EN undefined: same-address read and write SHALL return read-first data (old mem content); the write still takes effect for later reads.

Structure
REQ-030 A shared package sram_pkg SHALL hold the FSM state typedef (INIT, READY) and the byte lane width constant (8).
REQ-031 SHALL instantiate one sub-module sram_init_ctrl containing the FSM, clear counter and init_busy; the storage array, byte-merge and read register stay in sram_2p_be.

Verification
REQ-032 Reset then release -> init_busy=1 for exactly 16 cycles (defaults), then 0; read of addr 5 -> rdata=0x00000000, rvalid=1 one cycle later.
REQ-033 Write addr 3 data 0xDEADBEEF wbe=0xF, then write addr 3 data 0x11223344 wbe=0x5, read addr 3 -> rdata=0xDE22BE44.
REQ-034 Same cycle: write addr 7 0xA5A5A5A5 wbe=0xF and read addr 7 (mem[7]=0) -> rdata=0xA5A5A5A5 with bypass macro, 0x00000000 without; next read of 7 -> 0xA5A5A5A5 in both builds.
REQ-035 w_en=1, r_en=1 during INIT at addr 2 with 0xFFFFFFFF -> no rvalid pulse; after INIT, read addr 2 -> 0x00000000.
REQ-036 Assert rst_n=0 for one cycle when clr_cnt=9 after a write to addr 15 -> init_busy restarts for 16 full cycles; afterwards read addr 15 -> 0x00000000.
REQ-037 Back-to-back reads of addr 0,1,2 on consecutive cycles -> three consecutive rvalid pulses with matching data; r_en=0 afterwards -> rvalid=0, rdata holds last value.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the two-port byte-enable SRAM block.
// Build option: SRAM_2P_BE_BYPASS_EN selects write-first same-address reads.
package sram_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/sram_2p_be_if.sv
// Write/read bus of the two-port SRAM; master drives requests, slave returns data.
interface sram_2p_be_if #(
    parameter int WIDTH     = 32,
    parameter int ADDRWIDTH = 4
);
    localparam int NBYTE = WIDTH / 8;

    logic                 w_en;
    logic [ADDRWIDTH-1:0] waddr;
    logic [WIDTH-1:0]     wdata;
    logic [NBYTE-1:0]     wbe;
    logic                 r_en;
    logic [ADDRWIDTH-1:0] raddr;
    logic [WIDTH-1:0]     rdata;
    logic                 rvalid;
    logic                 init_busy;

    modport master (
        output w_en, waddr, wdata, wbe, r_en, raddr,
        input  rdata, rvalid, init_busy
    );

    modport slave (
        input  w_en, waddr, wdata, wbe, r_en, raddr,
        output rdata, rvalid, init_busy
    );

endinterface

// File: rtl/sram_init_ctrl.sv
// Post-reset clear sequencer: walks every entry once writing zero, then
// reports READY. init_busy is a flop tracking the INIT state.
module sram_init_ctrl
    import sram_pkg::*;
#(
    parameter int ADDRWIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 clr_we,
    output logic [ADDRWIDTH-1:0] clr_addr,
    output logic                 ready,
    output logic                 init_busy
);

    init_state_e          state_r;
    init_state_e          state_next_s;
    logic [ADDRWIDTH-1:0] clr_cnt_r;
    logic [ADDRWIDTH-1:0] clr_cnt_next_s;
    logic                 busy_r;

    // State, clear counter and busy flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= INIT;
            clr_cnt_r <= {ADDRWIDTH{1'b0}};
            busy_r    <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
            busy_r    <= (state_next_s == INIT);
        end
    end

    // Next-state and clear-port decode
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        clr_we         = 1'b0;
        ready          = 1'b0;
        case (state_r)
            INIT: begin
                clr_we         = 1'b1;
                clr_cnt_next_s = clr_cnt_r + {{(ADDRWIDTH-1){1'b0}}, 1'b1};
                if (clr_cnt_r == {ADDRWIDTH{1'b1}}) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = INIT;
                end
            end
            READY: begin
                ready        = 1'b1;
                state_next_s = READY;
            end
            default: begin
                state_next_s   = INIT;
                clr_cnt_next_s = {ADDRWIDTH{1'b0}};
            end
        endcase
    end

    assign clr_addr  = clr_cnt_r;
    assign init_busy = busy_r;

endmodule

// File: rtl/sram_2p_be.sv
// Two-port SRAM (one write, one read) with byte enables, registered read data
// and a post-reset zeroing pass. Build option: SRAM_2P_BE_BYPASS_EN.
module sram_2p_be
    import sram_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int ADDRWIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sram_2p_be_if.slave  bus
);

    localparam int NBYTE = WIDTH / BYTE_W;
    localparam int DEPTH = 2 ** ADDRWIDTH;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic                 clr_we_s;
    logic [ADDRWIDTH-1:0] clr_addr_s;
    logic                 ready_s;
    logic                 init_busy_s;
    logic                 wr_acc_s;
    logic                 rd_acc_s;
    logic [WIDTH-1:0]     rd_word_s;
    logic [WIDTH-1:0]     rdata_r;
    logic                 rvalid_r;

`ifdef SRAM_2P_BE_BYPASS_EN
    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_word,
        input logic [WIDTH-1:0] new_word,
        input logic [NBYTE-1:0] be
    );
        logic [WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTE; i++) begin
            if (be[i]) begin
                res[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction
`endif

    sram_init_ctrl #(
        .ADDRWIDTH (ADDRWIDTH)
    ) u_init_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we_s),
        .clr_addr  (clr_addr_s),
        .ready     (ready_s),
        .init_busy (init_busy_s)
    );

    assign wr_acc_s = rst_n & ready_s & bus.w_en;
    assign rd_acc_s = rst_n & ready_s & bus.r_en;

    // Storage: clear pass while initialising, byte-lane writes once ready
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem[clr_addr_s] <= {WIDTH{1'b0}};
        end else if (wr_acc_s) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (bus.wbe[i]) begin
                    mem[bus.waddr][i*BYTE_W +: BYTE_W] <= bus.wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read word select; same-address forwarding only in the bypass build
    always_comb begin
        rd_word_s = mem[bus.raddr];
`ifdef SRAM_2P_BE_BYPASS_EN
        if (wr_acc_s && (bus.waddr == bus.raddr)) begin
            rd_word_s = merge_lanes(mem[bus.raddr], bus.wdata, bus.wbe);
        end else begin
            rd_word_s = mem[bus.raddr];
        end
`endif
    end

    // Read data register and its one-cycle qualifier
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r  <= {WIDTH{1'b0}};
            rvalid_r <= 1'b0;
        end else begin
            rvalid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rdata_r <= rd_word_s;
            end
        end
    end

    assign bus.rdata     = rdata_r;
    assign bus.rvalid    = rvalid_r;
    assign bus.init_busy = init_busy_s;

endmodule

// File: tb/tb_sram_2p_be.sv
// Directed bench for sram_2p_be: vector table for steady-state traffic plus
// hand-written reset/init sequences.
module tb_sram_2p_be;

`ifdef SRAM_2P_BE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        w_en;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        r_en;
        logic [3:0]  raddr;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks_total = 0;
    int   checks_passed = 0;
    vec_t vecs [21];

    sram_2p_be_if #(.WIDTH(32), .ADDRWIDTH(4)) bus ();

    sram_2p_be #(.WIDTH(32), .ADDRWIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_en  = 1'b0;
        bus.waddr = 4'd0;
        bus.wdata = 32'h0;
        bus.wbe   = 4'h0;
        bus.r_en  = 1'b0;
        bus.raddr = 4'd0;
    endtask

    task automatic read(input logic [3:0] a, input logic [31:0] exp, input string name);
        bus.r_en  = 1'b1;
        bus.raddr = a;
        step();
        bus.r_en  = 1'b0;
        check({name, " rvalid"}, {31'd0, bus.rvalid}, 32'd1);
        check({name, " rdata"}, bus.rdata, exp);
    endtask

    // Counts samples with init_busy high, the first already taken; bounded.
    task automatic count_busy(input string name, output int busy_cnt, output int rv_seen);
        busy_cnt = 1;
        rv_seen  = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (bus.rvalid) rv_seen++;
            if (bus.init_busy) busy_cnt++;
            else break;
        end
        check({name, " busy cycles"}, busy_cnt, 32'd16);
    endtask

    initial begin
        int nbusy;
        int nrv;

        vecs[0]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd5,  1'b1, 32'h0};
        vecs[1]  = '{1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  1'b0, 32'h0};
        vecs[2]  = '{1'b1, 4'd3, 32'h11223344, 4'h5, 1'b0, 4'd0,  1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 4'd3, 32'hFFFFFFFF, 4'h0, 1'b0, 4'd0,  1'b0, 32'hDE22BE44};
        vecs[5]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd3,  1'b1, 32'hDE22BE44};
        vecs[6]  = '{1'b1, 4'd7, 32'hA5A5A5A5, 4'hF, 1'b1, 4'd7,  1'b1, BYP ? 32'hA5A5A5A5 : 32'h0};
        vecs[7]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7,  1'b1, 32'hA5A5A5A5};
        vecs[8]  = '{1'b1, 4'd9, 32'h01020304, 4'hF, 1'b1, 4'd3,  1'b1, 32'hDE22BE44};
        vecs[9]  = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd9,  1'b1, 32'h01020304};
        vecs[10] = '{1'b1, 4'd7, 32'h0000FF00, 4'h2, 1'b1, 4'd7,  1'b1, BYP ? 32'hA5A5FFA5 : 32'hA5A5A5A5};
        vecs[11] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd7,  1'b1, 32'hA5A5FFA5};
        vecs[12] = '{1'b1, 4'd0, 32'h00000010, 4'hF, 1'b0, 4'd0,  1'b0, 32'hA5A5FFA5};
        vecs[13] = '{1'b1, 4'd1, 32'h00000011, 4'hF, 1'b0, 4'd0,  1'b0, 32'hA5A5FFA5};
        vecs[14] = '{1'b1, 4'd2, 32'h00000012, 4'hF, 1'b0, 4'd0,  1'b0, 32'hA5A5FFA5};
        vecs[15] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd0,  1'b1, 32'h00000010};
        vecs[16] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd1,  1'b1, 32'h00000011};
        vecs[17] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd2,  1'b1, 32'h00000012};
        vecs[18] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd2,  1'b0, 32'h00000012};
        vecs[19] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b0, 4'd0,  1'b0, 32'h00000012};
        vecs[20] = '{1'b0, 4'd0, 32'h0,        4'h0, 1'b1, 4'd15, 1'b1, 32'h0};

        // Reset with a read pending: nothing may come out of it
        idle();
        bus.r_en  = 1'b1;
        bus.raddr = 4'd5;
        rst_n = 1'b0;
        step();
        step();
        check("reset init_busy", {31'd0, bus.init_busy}, 32'd1);
        check("reset rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("reset rdata", bus.rdata, 32'h0);

        // First init pass with requests that must be ignored
        bus.w_en  = 1'b1;
        bus.waddr = 4'd2;
        bus.wdata = 32'hFFFFFFFF;
        bus.wbe   = 4'hF;
        bus.r_en  = 1'b1;
        bus.raddr = 4'd2;
        rst_n = 1'b1;
        count_busy("init1", nbusy, nrv);
        check("init1 no rvalid", nrv, 32'd0);
        idle();
        read(4'd2, 32'h0, "addr2 cleared");

        foreach (vecs[i]) begin
            bus.w_en  = vecs[i].w_en;
            bus.waddr = vecs[i].waddr;
            bus.wdata = vecs[i].wdata;
            bus.wbe   = vecs[i].wbe;
            bus.r_en  = vecs[i].r_en;
            bus.raddr = vecs[i].raddr;
            step();
            check($sformatf("vec%0d rvalid", i), {31'd0, bus.rvalid}, {31'd0, vecs[i].exp_rvalid});
            check($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
        end
        idle();
        step();
        check("idle rvalid", {31'd0, bus.rvalid}, 32'd0);

        // Write 15, then reset again and abort that init at clr_cnt=9
        bus.w_en  = 1'b1;
        bus.waddr = 4'd15;
        bus.wdata = 32'hCAFEF00D;
        bus.wbe   = 4'hF;
        step();
        idle();
        read(4'd15, 32'hCAFEF00D, "addr15 written");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) step();
        check("mid-init busy", {31'd0, bus.init_busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        count_busy("init restart", nbusy, nrv);
        read(4'd15, 32'h0, "addr15 cleared");
        read(4'd3, 32'h0, "addr3 cleared");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
